// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and default sizing for the interrupt controller
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  localparam int NUM_IRQ_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int ID_W_DEF = $clog2(NUM_IRQ_DEF);
endpackage

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: synchronizer chain plus one-cycle rising-edge pulse for one request line
import irq_pkg::*;
module irq_sync_edge #(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  output logic rise_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  // shift the async line through the chain and remember the last synchronized level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: latches synchronized request edges and presents one prioritized interrupt at a time
import irq_pkg::*;
module irq_controller #(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         irq_in,
  input  logic [NUM_IRQ-1:0]         irq_mask,
  input  logic                       int_ack,
  input  logic                       int_done,
  output logic                       int_sig,
  output logic [$clog2(NUM_IRQ)-1:0] int_id,
  output logic [NUM_IRQ-1:0]         pending,
  output logic                       busy
);
  localparam int IDW = $clog2(NUM_IRQ);
  state_t state_q;
  logic sig_q, busy_q;
  logic [IDW-1:0] id_q, win;
  logic [NUM_IRQ-1:0] rise, req, clr, pending_q, pending_d;
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .irq_i(irq_in[i]),
      .rise_o(rise[i])
    );
  end
  assign req = pending_q & irq_mask;
  assign clr = (state_q == REQ && int_ack) ? NUM_IRQ'(1) << id_q : '0;
  // a fresh edge on the line being acked wins over the clear
  assign pending_d = (pending_q & ~clr) | rise;
  // fixed priority: lowest enabled pending index
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) win = req[i] ? IDW'(i) : win;
  end
  // pending event register
  always_ff @(posedge clk or posedge rst)
    if (rst) pending_q <= '0;
    else pending_q <= pending_d;
  // request handshake: raise, wait for ack, wait for return-from-interrupt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sig_q <= 1'b0;
      id_q <= '0;
      busy_q <= 1'b0;
    end else
      case (state_q)
        IDLE: if (|req) begin
          state_q <= REQ;
          sig_q <= 1'b1;
          id_q <= win;
          busy_q <= 1'b1;
        end
        REQ: if (int_ack) begin
          state_q <= SERVICE;
          sig_q <= 1'b0;
        end
        SERVICE: if (int_done) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
  assign int_sig = sig_q;
  assign int_id = id_q;
  assign pending = pending_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus with a request-id scoreboard and point checks
module tb_irq_controller;
  logic clk = 0, rst = 1, int_ack = 0, int_done = 0;
  logic [3:0] irq_in = 0, irq_mask = 4'hF;
  logic int_sig, busy;
  logic [1:0] int_id;
  logic [3:0] pending;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] exp_q[$];
  logic prev_sig = 0;
  irq_controller dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask),
    .int_ack(int_ack), .int_done(int_done), .int_sig(int_sig),
    .int_id(int_id), .pending(pending), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic pulse(input logic [3:0] m);
    irq_in = irq_in | m;
    ticks(2);
    irq_in = irq_in & ~m;
  endtask
  task automatic serve();
    int_ack = 1;
    tick();
    int_ack = 0;
    int_done = 1;
    tick();
    int_done = 0;
  endtask
  // monitor: every new request to the core is checked against the scoreboard
  always @(negedge clk) begin
    if (int_sig && !prev_sig) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected request: got id %0d expected none", int_id);
      end else chk("req id", int_id, exp_q.pop_front());
    end
    prev_sig <= int_sig;
  end
  initial begin
    int quiet;
    ticks(2);
    chk("rst int_sig", int_sig, 0);
    chk("rst int_id", int_id, 0);
    chk("rst pending", pending, 0);
    chk("rst busy", busy, 0);
    rst = 0;
    tick();
    // single line, latency and handshake
    exp_q.push_back(2);
    pulse(4'b0100);
    chk("t1 pending early", pending, 0);
    tick();
    chk("t1 pending", pending, 4'b0100);
    chk("t1 sig early", int_sig, 0);
    tick();
    chk("t1 sig", int_sig, 1);
    chk("t1 id", int_id, 2);
    chk("t1 busy req", busy, 1);
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("t1 sig after ack", int_sig, 0);
    chk("t1 pending after ack", pending, 0);
    chk("t1 busy service", busy, 1);
    int_done = 1;
    tick();
    int_done = 0;
    chk("t1 busy after done", busy, 0);
    // simultaneous arrivals, lowest index first
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse(4'b1010);
    tick();
    chk("t2 pending", pending, 4'b1010);
    tick();
    chk("t2 sig", int_sig, 1);
    chk("t2 id first", int_id, 1);
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("t2 pending after ack", pending, 4'b1000);
    int_done = 1;
    tick();
    int_done = 0;
    chk("t2 gap", int_sig, 0);
    tick();
    chk("t2 sig second", int_sig, 1);
    chk("t2 id second", int_id, 3);
    serve();
    // masked pending line waits for unmask
    irq_mask = 4'b1110;
    pulse(4'b0001);
    tick();
    chk("t3 pending masked", pending, 4'b0001);
    quiet = 0;
    repeat (20) begin
      tick();
      if (int_sig) quiet++;
    end
    chk("t3 masked quiet", quiet, 0);
    exp_q.push_back(0);
    irq_mask = 4'hF;
    tick();
    chk("t3 sig unmask", int_sig, 1);
    chk("t3 id unmask", int_id, 0);
    serve();
    // higher priority arrival does not retract active request
    exp_q.push_back(1);
    pulse(4'b0010);
    ticks(2);
    chk("t4 sig", int_sig, 1);
    chk("t4 id", int_id, 1);
    exp_q.push_back(0);
    pulse(4'b0001);
    tick();
    chk("t4 pending both", pending, 4'b0011);
    chk("t4 id held", int_id, 1);
    chk("t4 sig held", int_sig, 1);
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("t4 pending after ack", pending, 4'b0001);
    int_done = 1;
    tick();
    int_done = 0;
    tick();
    chk("t4 sig next", int_sig, 1);
    chk("t4 id next", int_id, 0);
    serve();
    // new edge coincident with ack keeps the line pending
    exp_q.push_back(2);
    pulse(4'b0100);
    ticks(2);
    chk("t5 sig", int_sig, 1);
    chk("t5 id", int_id, 2);
    irq_in[2] = 1;
    ticks(2);
    irq_in[2] = 0;
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("t5 pending kept", pending, 4'b0100);
    chk("t5 sig after ack", int_sig, 0);
    chk("t5 busy", busy, 1);
    exp_q.push_back(2);
    int_done = 1;
    tick();
    int_done = 0;
    tick();
    chk("t5 sig again", int_sig, 1);
    chk("t5 id again", int_id, 2);
    serve();
    chk("t5 pending clear", pending, 0);
    // asynchronous reset while in service
    exp_q.push_back(3);
    pulse(4'b1000);
    ticks(2);
    chk("t6 sig", int_sig, 1);
    chk("t6 id", int_id, 3);
    int_ack = 1;
    tick();
    int_ack = 0;
    chk("t6 busy service", busy, 1);
    rst = 1;
    #1;
    chk("t6 async sig", int_sig, 0);
    chk("t6 async id", int_id, 0);
    chk("t6 async pending", pending, 0);
    chk("t6 async busy", busy, 0);
    tick();
    rst = 0;
    int_done = 1;
    tick();
    int_done = 0;
    ticks(3);
    chk("t6 done ignored busy", busy, 0);
    chk("t6 done ignored sig", int_sig, 0);
    // line high across reset release counts as an edge
    rst = 1;
    irq_in = 4'b0010;
    tick();
    rst = 0;
    exp_q.push_back(1);
    ticks(3);
    chk("t7 pending", pending, 4'b0010);
    chk("t7 sig early", int_sig, 0);
    tick();
    chk("t7 sig", int_sig, 1);
    chk("t7 id", int_id, 1);
    irq_in = 0;
    serve();
    ticks(2);
    chk("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
